// File: rtl/demux1x2_buffered_if.sv
// Handshake bundle for the buffered 1:2 demux: one input stream, two output channels, a counter.
interface demux1x2_buffered_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
);
   logic [WIDTH-1:0] inp;
   logic             inp_valid;
   logic             inp_ready;
   logic             sel;
   logic             auto_mode;
   logic             sync;
   logic [WIDTH-1:0] out0;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out1;
   logic             out1_valid;
   logic             out1_ready;
   logic [CNT_W-1:0] xfer_count;

   modport master (
      output inp, inp_valid, sel, auto_mode, sync, out0_ready, out1_ready,
      input  inp_ready, out0, out0_valid, out1, out1_valid, xfer_count
   );

   modport slave (
      input  inp, inp_valid, sel, auto_mode, sync, out0_ready, out1_ready,
      output inp_ready, out0, out0_valid, out1, out1_valid, xfer_count
   );
endinterface

// File: rtl/demux1x2_buffered.sv
// Registered 1:2 demux with one-entry valid/ready buffer per output channel.
// Destination comes from sel or from a real/imag alternation FSM.
module demux1x2_buffered #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input logic                clk,
   input logic                rst,
   demux1x2_buffered_if.slave bus
);
   typedef enum logic {NEXT0 = 1'b0, NEXT1 = 1'b1} state_t;

   state_t                       state, state_nxt;
   logic                         dst;
   logic                         accept;
   logic [1:0]                   rdy;
   logic [1:0]                   vld;
   logic [1:0]                   free;
   logic [1:0][WIDTH-1:0]        data;
   logic [CNT_W-1:0]             cnt;

   assign rdy    = {bus.out1_ready, bus.out0_ready};
   // A full channel still counts as free when it drains in this same cycle.
   assign free   = ~vld | rdy;
   assign accept = bus.inp_valid && bus.inp_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= NEXT0;
      else     state <= state_nxt;
   end

   // sync outranks advance; the current state still steers a same-cycle accept.
   always_comb begin
      state_nxt = state;
      if (bus.sync)
         state_nxt = NEXT0;
      else if (accept && bus.auto_mode)
         state_nxt = (state == NEXT0) ? NEXT1 : NEXT0;
   end

   always_comb begin
      dst           = bus.auto_mode ? (state == NEXT1) : bus.sel;
      bus.inp_ready = free[dst];
   end

   for (genvar c = 0; c < 2; c++) begin : g_ch
      always_ff @(posedge clk) begin
         if (rst) begin
            data[c] <= '0;
            vld[c]  <= 1'b0;
         end else if (accept && (dst == c[0])) begin
            data[c] <= bus.inp;
            vld[c]  <= 1'b1;
         end else if (vld[c] && rdy[c]) begin
            vld[c]  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         cnt <= '0;
      else if (accept) cnt <= cnt + 1'b1;
   end

   assign bus.out0       = data[0];
   assign bus.out1       = data[1];
   assign bus.out0_valid = vld[0];
   assign bus.out1_valid = vld[1];
   assign bus.xfer_count = cnt;
endmodule

// File: tb/tb_demux1x2_buffered.sv
// Directed + random bench for demux1x2_buffered; per-channel expected-data queues checked by a monitor.
module tb_demux1x2_buffered;
   localparam int WIDTH = 4;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   demux1x2_buffered_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   demux1x2_buffered #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int compared = 0;
   int mismatched = 0;
   bit started = 0;

   // Reference model: occupancy, last loaded value, pending words, pairing parity, count.
   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];
   bit               m_full[2]  = '{0, 0};
   logic [WIDTH-1:0] m_last[2]  = '{0, 0};
   bit               m_odd      = 0;
   int               m_cnt      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drain_check(input int c, input logic [WIDTH-1:0] outv);
      logic [WIDTH-1:0] e;
      if (c == 0) begin
         if (q0.size() == 0) begin chk("drain0_queue_empty", 1, 0); return; end
         e = q0.pop_front();
      end else begin
         if (q1.size() == 0) begin chk("drain1_queue_empty", 1, 0); return; end
         e = q1.pop_front();
      end
      chk(c == 0 ? "drain0_data" : "drain1_data", outv, e);
   endtask

   always @(negedge clk) begin
      bit d;
      bit r;
      bit rd[2];
      if (started) begin
         chk("out0_valid", bus.out0_valid, m_full[0]);
         chk("out1_valid", bus.out1_valid, m_full[1]);
         chk("out0", bus.out0, m_last[0]);
         chk("out1", bus.out1, m_last[1]);
         chk("xfer_count", bus.xfer_count, m_cnt % (1 << CNT_W));
      end
      rd[0] = bus.out0_ready;
      rd[1] = bus.out1_ready;
      d = bus.auto_mode ? m_odd : bus.sel;
      r = !m_full[d] || rd[d];
      if (started) chk("inp_ready", bus.inp_ready, r);
      if (rst) begin
         q0.delete(); q1.delete();
         m_full = '{0, 0};
         m_last = '{0, 0};
         m_odd  = 0;
         m_cnt  = 0;
      end else begin
         for (int c = 0; c < 2; c++) begin
            if (m_full[c] && rd[c]) begin
               drain_check(c, c == 0 ? bus.out0 : bus.out1);
               m_full[c] = 0;
            end
         end
         if (bus.inp_valid && r) begin
            if (d) q1.push_back(bus.inp); else q0.push_back(bus.inp);
            m_last[d] = bus.inp;
            m_full[d] = 1;
            m_cnt++;
            if (bus.auto_mode) m_odd = !m_odd;
         end
         if (bus.sync) m_odd = 0;
      end
   end

   task automatic drive(input bit rs, input bit v, input logic [WIDTH-1:0] d, input bit s,
                        input bit au, input bit sy, input bit r0, input bit r1);
      rst            = rs;
      bus.inp_valid  = v;
      bus.inp        = d;
      bus.sel        = s;
      bus.auto_mode  = au;
      bus.sync       = sy;
      bus.out0_ready = r0;
      bus.out1_ready = r1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      drive(1, 1, 4'hF, 0, 0, 0, 1, 1);
      started = 1;
      // reset holds with a word presented
      drive(1, 1, 4'hF, 0, 0, 0, 1, 1);
      // manual steer
      drive(0, 1, 4'h3, 0, 0, 0, 1, 1);
      drive(0, 1, 4'hA, 1, 0, 0, 1, 1);
      drive(0, 0, 4'h0, 0, 0, 0, 1, 1);
      // backpressure on out1 leaves out0 usable
      drive(0, 1, 4'h8, 1, 0, 0, 1, 0);
      drive(0, 1, 4'h5, 1, 0, 0, 1, 0);
      drive(0, 1, 4'h6, 0, 0, 0, 1, 0);
      drive(0, 1, 4'h5, 1, 0, 0, 1, 1);
      drive(0, 0, 4'h0, 0, 0, 0, 1, 1);
      // auto pairing
      for (int i = 1; i <= 4; i++) drive(0, 1, 4'(i), 0, 1, 0, 1, 1);
      drive(0, 0, 4'h0, 0, 1, 0, 1, 1);
      // sync with accept in NEXT1
      drive(0, 1, 4'h1, 0, 1, 0, 1, 1);
      drive(0, 1, 4'h7, 0, 1, 1, 1, 1);
      drive(0, 1, 4'h2, 0, 0, 0, 0, 1);
      drive(0, 1, 4'h9, 0, 0, 0, 1, 1);
      drive(0, 0, 4'h0, 0, 0, 0, 1, 1);
      // counter wrap, then mid-stream reset
      for (int i = 0; i < 16; i++) drive(0, 1, 4'(i), i[0], 0, 0, 1, 1);
      drive(0, 1, 4'hC, 0, 0, 0, 0, 0);
      drive(1, 1, 4'hD, 1, 0, 0, 0, 0);
      drive(0, 0, 4'h0, 0, 0, 0, 1, 1);
      // random traffic
      begin
         bit au;
         au = 0;
         for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) au = !au;
            drive($urandom_range(199) == 0, $urandom_range(3) != 0, 4'($urandom),
                  1'($urandom), au, $urandom_range(15) == 0,
                  $urandom_range(3) != 0, $urandom_range(3) != 0);
         end
      end
      drive(0, 0, 4'h0, 0, 0, 0, 1, 1);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
